// File: rtl/sent_rx_crc_check_if.sv
// Bus between the SENT RX nibble decoder/host and the CRC checker.
// master drives message data and received CRC; slave is the checker.
interface sent_rx_crc_check_if;
  logic [2:0] crc_mode;
  logic       frame_start;
  logic [3:0] nibble_in;
  logic       nibble_valid;
  logic [5:0] rx_crc;
  logic       rx_crc_valid;
  logic       busy;
  logic [5:0] crc_calc;
  logic       crc_done;
  logic       crc_ok;
  logic       crc_err;
  logic       mode_err;
  logic       abort;

  modport master (
    output crc_mode, frame_start, nibble_in, nibble_valid, rx_crc, rx_crc_valid,
    input  busy, crc_calc, crc_done, crc_ok, crc_err, mode_err, abort
  );

  modport slave (
    input  crc_mode, frame_start, nibble_in, nibble_valid, rx_crc, rx_crc_valid,
    output busy, crc_calc, crc_done, crc_ok, crc_err, mode_err, abort
  );
endinterface

// File: rtl/sent_rx_crc_check.sv
// SENT receive CRC checker. Computes CRC4 (fast / short serial) or CRC6
// (enhanced serial) over the incoming data nibbles one nibble per cycle,
// then compares against the received CRC and pulses crc_done.
module sent_rx_crc_check (
  input  logic                    clk,
  input  logic                    reset_n,
  sent_rx_crc_check_if.slave      bus
);

  typedef enum logic [1:0] {IDLE, DATA, AUGMENT, WAIT_CRC} state_t;

  localparam logic [5:0] SEED4 = 6'b000101;
  localparam logic [5:0] SEED6 = 6'b010101;
  localparam logic [3:0] POLY4 = 4'b1101;    // x^4+x^3+x^2+1 without the x^4 term
  localparam logic [5:0] POLY6 = 6'b011001;  // x^6+x^4+x^3+1 without the x^6 term

  // One bit of the MSB-first CRC shift; in CRC4 mode bits [5:4] stay zero.
  function automatic logic [5:0] crc_bit(input logic [5:0] r, input logic b,
                                         input logic enh);
    logic [5:0] n;
    if (enh) begin
      n = {r[4:0], b} ^ (r[5] ? POLY6 : 6'b000000);
    end else begin
      n = {2'b00, ({r[2:0], b} ^ (r[3] ? POLY4 : 4'b0000))};
    end
    return n;
  endfunction

  // Four data bits per accepted nibble, most significant bit first.
  function automatic logic [5:0] crc_nibble(input logic [5:0] r, input logic [3:0] nib,
                                            input logic enh);
    logic [5:0] t;
    t = r;
    for (int i = 3; i >= 0; i--) begin
      t = crc_bit(t, nib[i], enh);
    end
    return t;
  endfunction

  // Shift in W zero bits (4 for CRC4, 6 for CRC6) to finish the division.
  function automatic logic [5:0] crc_augment(input logic [5:0] r, input logic enh);
    logic [5:0] t;
    t = r;
    for (int i = 0; i < 6; i++) begin
      if (enh || (i < 4)) begin
        t = crc_bit(t, 1'b0, enh);
      end
    end
    return t;
  endfunction

  state_t     state_reg, state_next;
  logic       enh_reg, enh_next;
  logic [2:0] len_reg, len_next;
  logic [2:0] cnt_reg, cnt_next;
  logic [5:0] r_reg, r_next;
  logic [5:0] hold_reg, hold_next;
  logic       hold_valid_reg, hold_valid_next;
  logic [5:0] crc_calc_reg, crc_calc_next;
  logic       crc_done_reg, crc_done_next;
  logic       crc_ok_reg, crc_ok_next;
  logic       crc_err_reg, crc_err_next;
  logic       mode_err_reg, mode_err_next;
  logic       abort_reg, abort_next;

  logic       mode_ok;
  logic       mode_enh;
  logic [2:0] mode_len;
  logic       crc_match;

  // Decode the message type into nibble count and CRC width.
  always_comb begin
    mode_ok  = 1'b1;
    mode_enh = 1'b0;
    mode_len = 3'd3;
    case (bus.crc_mode)
      3'b100:  mode_len = 3'd3;
      3'b001:  mode_len = 3'd6;
      3'b010:  mode_len = 3'd4;
      3'b011:  mode_len = 3'd3;
      3'b101: begin
        mode_len = 3'd6;
        mode_enh = 1'b1;
      end
      default: mode_ok = 1'b0;
    endcase
  end

  // CRC4 modes only compare the low nibble of the received CRC.
  assign crc_match = enh_reg ? (hold_reg == crc_calc_reg)
                             : (hold_reg[3:0] == crc_calc_reg[3:0]);

  // Next-state and datapath logic; pulses default low every cycle.
  always_comb begin
    state_next      = state_reg;
    enh_next        = enh_reg;
    len_next        = len_reg;
    cnt_next        = cnt_reg;
    r_next          = r_reg;
    hold_next       = hold_reg;
    hold_valid_next = hold_valid_reg;
    crc_calc_next   = crc_calc_reg;
    crc_ok_next     = crc_ok_reg;
    crc_done_next   = 1'b0;
    crc_err_next    = 1'b0;
    mode_err_next   = 1'b0;
    abort_next      = 1'b0;

    if (bus.frame_start) begin
      // A new frame always wins: drop any partial frame and restart.
      abort_next      = (state_reg != IDLE);
      crc_ok_next     = 1'b0;
      hold_valid_next = 1'b0;
      if (mode_ok) begin
        state_next = DATA;
        enh_next   = mode_enh;
        len_next   = mode_len;
        cnt_next   = 3'd0;
        r_next     = mode_enh ? SEED6 : SEED4;
      end else begin
        mode_err_next = 1'b1;
        state_next    = IDLE;
      end
    end else begin
      case (state_reg)
        DATA: begin
          if (bus.nibble_valid) begin
            r_next   = crc_nibble(r_reg, bus.nibble_in, enh_reg);
            cnt_next = cnt_reg + 3'd1;
            if (cnt_reg == (len_reg - 3'd1)) begin
              state_next = AUGMENT;
            end
          end
          if (bus.rx_crc_valid) begin
            hold_next       = bus.rx_crc;
            hold_valid_next = 1'b1;
          end
        end
        AUGMENT: begin
          r_next        = crc_augment(r_reg, enh_reg);
          crc_calc_next = crc_augment(r_reg, enh_reg);
          state_next    = WAIT_CRC;
          if (bus.rx_crc_valid) begin
            hold_next       = bus.rx_crc;
            hold_valid_next = 1'b1;
          end
        end
        WAIT_CRC: begin
          if (hold_valid_reg) begin
            // Compare the CRC latched on an earlier edge.
            crc_done_next   = 1'b1;
            crc_ok_next     = crc_match;
            crc_err_next    = !crc_match;
            hold_valid_next = 1'b0;
            state_next      = IDLE;
          end else if (bus.rx_crc_valid) begin
            hold_next       = bus.rx_crc;
            hold_valid_next = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      enh_reg        <= 1'b0;
      len_reg        <= 3'd0;
      cnt_reg        <= 3'd0;
      r_reg          <= 6'd0;
      hold_reg       <= 6'd0;
      hold_valid_reg <= 1'b0;
      crc_calc_reg   <= 6'd0;
      crc_done_reg   <= 1'b0;
      crc_ok_reg     <= 1'b0;
      crc_err_reg    <= 1'b0;
      mode_err_reg   <= 1'b0;
      abort_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      enh_reg        <= enh_next;
      len_reg        <= len_next;
      cnt_reg        <= cnt_next;
      r_reg          <= r_next;
      hold_reg       <= hold_next;
      hold_valid_reg <= hold_valid_next;
      crc_calc_reg   <= crc_calc_next;
      crc_done_reg   <= crc_done_next;
      crc_ok_reg     <= crc_ok_next;
      crc_err_reg    <= crc_err_next;
      mode_err_reg   <= mode_err_next;
      abort_reg      <= abort_next;
    end
  end

  assign bus.busy     = (state_reg != IDLE);
  assign bus.crc_calc = crc_calc_reg;
  assign bus.crc_done = crc_done_reg;
  assign bus.crc_ok   = crc_ok_reg;
  assign bus.crc_err  = crc_err_reg;
  assign bus.mode_err = mode_err_reg;
  assign bus.abort    = abort_reg;

endmodule

// File: tb/tb_sent_rx_crc_check.sv
// Self-checking bench for sent_rx_crc_check: directed vectors plus random
// frames checked against a polynomial long-division reference model.
module tb_sent_rx_crc_check;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  sent_rx_crc_check_if bus ();

  sent_rx_crc_check dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- reference model ----------------
  function automatic int mode_len(input logic [2:0] m);
    case (m)
      3'b100, 3'b011: return 3;
      3'b010:         return 4;
      3'b001, 3'b101: return 6;
      default:        return 0;
    endcase
  endfunction

  function automatic int mode_w(input logic [2:0] m);
    return (m == 3'b101) ? 6 : 4;
  endfunction

  // Remainder of {seed, data, W zeros} divided by the generator polynomial.
  function automatic logic [5:0] ref_crc(input logic [2:0] mode, input logic [23:0] data);
    int n, w, len;
    logic [63:0] msg, poly, seed, dmask;
    n = mode_len(mode);
    w = mode_w(mode);
    seed  = (w == 6) ? 64'h15 : 64'h05;
    poly  = (w == 6) ? 64'h59 : 64'h1D;
    dmask = (64'd1 << (4 * n)) - 64'd1;
    msg = (seed << (4 * n)) | ({40'd0, data} & dmask);
    msg = msg << w;
    len = w + 4 * n + w;
    for (int i = len - 1; i >= w; i--) begin
      if (msg[i]) msg = msg ^ (poly << (i - w));
    end
    return msg[5:0];
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle;
    bus.crc_mode     = 3'b000;
    bus.frame_start  = 1'b0;
    bus.nibble_in    = 4'h0;
    bus.nibble_valid = 1'b0;
    bus.rx_crc       = 6'h00;
    bus.rx_crc_valid = 1'b0;
  endtask

  // Sends one frame. rx_phase: 0 = CRC during DATA (a decoy first, then the
  // real value with the last nibble), 1 = during AUGMENT, 2 = in WAIT_CRC.
  // lat counts edges from the last-nibble edge (phases 0/1) or from the
  // edge that latched rx_crc (phase 2).
  task automatic send_frame(input logic [2:0] mode, input logic [23:0] data,
                            input logic [5:0] rx, input int rx_phase, input bit stall,
                            output bit abort_seen, output bit merr_seen,
                            output bit done_seen, output int lat,
                            output logic [5:0] calc, output logic ok,
                            output logic err, output bit early_done);
    int n, base;
    n = mode_len(mode);
    early_done = 1'b0;
    done_seen = 1'b0;
    lat = 0;
    calc = 6'h00;
    ok = 1'b0;
    err = 1'b0;
    bus.crc_mode = mode;
    bus.frame_start = 1'b1;
    step();
    abort_seen = bus.abort;
    merr_seen = bus.mode_err;
    bus.frame_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (stall && ($urandom_range(0, 2) == 0)) begin
        step();
        if (bus.crc_done) early_done = 1'b1;
      end
      bus.nibble_valid = 1'b1;
      bus.nibble_in = data[4 * (n - 1 - i) +: 4];
      if (rx_phase == 0 && i == 0) begin
        bus.rx_crc_valid = 1'b1;
        bus.rx_crc = rx ^ 6'h3F;
      end
      if (rx_phase == 0 && i == n - 1) begin
        bus.rx_crc_valid = 1'b1;
        bus.rx_crc = rx;
      end
      step();
      if (bus.crc_done) early_done = 1'b1;
      bus.nibble_valid = 1'b0;
      bus.rx_crc_valid = 1'b0;
    end
    base = 0;
    if (rx_phase == 1) begin
      bus.rx_crc_valid = 1'b1;
      bus.rx_crc = rx;
      step();
      if (bus.crc_done) early_done = 1'b1;
      bus.rx_crc_valid = 1'b0;
      base = 1;
    end else if (rx_phase == 2) begin
      step();
      if (bus.crc_done) early_done = 1'b1;
      bus.rx_crc_valid = 1'b1;
      bus.rx_crc = rx;
      step();
      if (bus.crc_done) early_done = 1'b1;
      bus.rx_crc_valid = 1'b0;
    end
    for (int k = base + 1; k <= base + 20 && !done_seen; k++) begin
      step();
      if (bus.crc_done) begin
        done_seen = 1'b1;
        lat = k;
        calc = bus.crc_calc;
        ok = bus.crc_ok;
        err = bus.crc_err;
      end
    end
    $display("[TB] frame mode=%b data=%06h rx=%02h phase=%0d done=%0b lat=%0d calc=%02h ok=%0b err=%0b",
             mode, data, rx, rx_phase, done_seen, lat, calc, ok, err);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    logic [15:0] outs;
    drive_idle();
    reset_n = 1'b0;
    repeat (3) step();
    outs = {bus.busy, bus.crc_calc, bus.crc_done, bus.crc_ok, bus.crc_err,
            bus.mode_err, bus.abort, 3'b000};
    tests_run++;
    if (outs !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_outputs got=%04h exp=0000", outs);
    end
    reset_n = 1'b1;
    step();
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_busy got=%b exp=0", bus.busy);
    end
    $display("[TB] reset released");
  endtask

  task automatic test_plan_vectors;
    bit ab, me, dn, ed;
    int lat;
    logic [5:0] calc;
    logic ok, err;
    // fast 3 nibbles, zeros, CRC arrives in WAIT_CRC
    send_frame(3'b011, 24'h000, 6'h09, 2, 1'b0, ab, me, dn, lat, calc, ok, err, ed);
    tests_run++;
    if (!dn || calc !== 6'h09 || ok !== 1'b1 || err !== 1'b0 || lat != 1 || ed) begin
      tests_failed++;
      $display("FAIL plan_m011 done=%0b lat=%0d calc=%02h ok=%b err=%b exp done=1 lat=1 calc=09 ok=1 err=0", dn, lat, calc, ok, err);
    end
    // short serial 0,0,1 match then mismatch
    send_frame(3'b100, 24'h001, 6'h04, 2, 1'b0, ab, me, dn, lat, calc, ok, err, ed);
    tests_run++;
    if (!dn || calc !== 6'h04 || ok !== 1'b1 || err !== 1'b0) begin
      tests_failed++;
      $display("FAIL plan_m100_ok done=%0b calc=%02h ok=%b err=%b exp calc=04 ok=1 err=0", dn, calc, ok, err);
    end
    send_frame(3'b100, 24'h001, 6'h05, 2, 1'b0, ab, me, dn, lat, calc, ok, err, ed);
    tests_run++;
    if (!dn || ok !== 1'b0 || err !== 1'b1) begin
      tests_failed++;
      $display("FAIL plan_m100_err done=%0b ok=%b err=%b exp ok=0 err=1", dn, ok, err);
    end
    // fast 4 and 6 nibbles, CRC given early -> done 2 edges after last nibble
    send_frame(3'b010, 24'h0000, 6'h0C, 0, 1'b0, ab, me, dn, lat, calc, ok, err, ed);
    tests_run++;
    if (!dn || calc !== 6'h0C || ok !== 1'b1 || lat != 2 || ed) begin
      tests_failed++;
      $display("FAIL plan_m010 done=%0b lat=%0d calc=%02h ok=%b exp lat=2 calc=0C ok=1", dn, lat, calc, ok);
    end
    send_frame(3'b001, 24'h000000, 6'h05, 0, 1'b0, ab, me, dn, lat, calc, ok, err, ed);
    tests_run++;
    if (!dn || calc !== 6'h05 || ok !== 1'b1 || lat != 2 || ed) begin
      tests_failed++;
      $display("FAIL plan_m001 done=%0b lat=%0d calc=%02h ok=%b exp lat=2 calc=05 ok=1", dn, lat, calc, ok);
    end
    // enhanced serial CRC6
    send_frame(3'b101, 24'h000000, 6'h26, 1, 1'b0, ab, me, dn, lat, calc, ok, err, ed);
    tests_run++;
    if (!dn || calc !== 6'h26 || ok !== 1'b1 || err !== 1'b0 || lat != 2) begin
      tests_failed++;
      $display("FAIL plan_m101_ok done=%0b lat=%0d calc=%02h ok=%b exp lat=2 calc=26 ok=1", dn, lat, calc, ok);
    end
    send_frame(3'b101, 24'h000000, 6'h06, 2, 1'b0, ab, me, dn, lat, calc, ok, err, ed);
    tests_run++;
    if (!dn || calc !== 6'h26 || ok !== 1'b0 || err !== 1'b1) begin
      tests_failed++;
      $display("FAIL plan_m101_err done=%0b calc=%02h ok=%b err=%b exp calc=26 ok=0 err=1", dn, calc, ok, err);
    end
  endtask

  task automatic test_random_frames;
    logic [2:0] modes [5];
    logic [2:0] mode;
    logic [23:0] data;
    logic [5:0] model, rx, calc;
    logic ok, err, exp_ok;
    bit ab, me, dn, ed;
    int lat, phase, exp_lat;
    modes[0] = 3'b100; modes[1] = 3'b001; modes[2] = 3'b010;
    modes[3] = 3'b011; modes[4] = 3'b101;
    for (int t = 0; t < 40; t++) begin
      mode = modes[$urandom_range(0, 4)];
      data = 24'($urandom());
      model = ref_crc(mode, data);
      if ($urandom_range(0, 1) == 1) begin
        rx = model;
        if (mode_w(mode) == 4) rx[5:4] = 2'($urandom());
      end else begin
        rx = 6'($urandom());
      end
      exp_ok = (mode_w(mode) == 6) ? (rx == model) : (rx[3:0] == model[3:0]);
      phase = $urandom_range(0, 2);
      exp_lat = (phase == 2) ? 1 : 2;
      send_frame(mode, data, rx, phase, 1'b1, ab, me, dn, lat, calc, ok, err, ed);
      tests_run++;
      if (!dn || ed || lat != exp_lat) begin
        tests_failed++;
        $display("FAIL rand_latency t=%0d done=%0b early=%0b lat=%0d exp lat=%0d", t, dn, ed, lat, exp_lat);
      end
      tests_run++;
      if (calc !== model) begin
        tests_failed++;
        $display("FAIL rand_crc_calc t=%0d mode=%b data=%06h got=%02h exp=%02h", t, mode, data, calc, model);
      end
      tests_run++;
      if (ok !== exp_ok || err !== !exp_ok) begin
        tests_failed++;
        $display("FAIL rand_verdict t=%0d ok=%b err=%b exp ok=%b err=%b", t, ok, err, exp_ok, !exp_ok);
      end
    end
  endtask

  task automatic test_abort;
    bit ab, me, dn, ed, stray;
    int lat;
    logic [5:0] calc;
    logic ok, err;
    logic [23:0] data;
    stray = 1'b0;
    bus.crc_mode = 3'b001;
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.nibble_valid = 1'b1;
      bus.nibble_in = 4'($urandom());
      bus.rx_crc_valid = (i == 0);
      bus.rx_crc = 6'h05;
      step();
      if (bus.crc_done) stray = 1'b1;
    end
    bus.nibble_valid = 1'b0;
    bus.rx_crc_valid = 1'b0;
    tests_run++;
    if (bus.busy !== 1'b1 || stray) begin
      tests_failed++;
      $display("FAIL abort_partial busy=%b stray_done=%0b exp busy=1 stray_done=0", bus.busy, stray);
    end
    // Restart while busy; the decoy CRC latched above must be discarded.
    data = 24'($urandom());
    send_frame(3'b011, data, ref_crc(3'b011, data), 2, 1'b0, ab, me, dn, lat, calc, ok, err, ed);
    tests_run++;
    if (ab !== 1'b1 || me !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_pulse abort=%b mode_err=%b exp abort=1 mode_err=0", ab, me);
    end
    tests_run++;
    if (!dn || ed || lat != 1 || calc !== ref_crc(3'b011, data) || ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_restart done=%0b early=%0b lat=%0d calc=%02h ok=%b exp lat=1 calc=%02h ok=1",
               dn, ed, lat, calc, ok, ref_crc(3'b011, data));
    end
  endtask

  task automatic test_mode_err;
    logic [2:0] bad [3];
    bad[0] = 3'b000; bad[1] = 3'b110; bad[2] = 3'b111;
    for (int i = 0; i < 3; i++) begin
      bus.crc_mode = bad[i];
      bus.frame_start = 1'b1;
      step();
      bus.frame_start = 1'b0;
      tests_run++;
      if (bus.mode_err !== 1'b1 || bus.busy !== 1'b0 || bus.abort !== 1'b0) begin
        tests_failed++;
        $display("FAIL mode_err_idle mode=%b mode_err=%b busy=%b abort=%b exp 1 0 0",
                 bad[i], bus.mode_err, bus.busy, bus.abort);
      end
      step();
      tests_run++;
      if (bus.mode_err !== 1'b0 || bus.busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL mode_err_pulse mode=%b mode_err=%b busy=%b exp 0 0", bad[i], bus.mode_err, bus.busy);
      end
      $display("[TB] invalid mode %b checked", bad[i]);
    end
  endtask

  task automatic test_back_to_back;
    bit ab, me, dn, ed;
    int lat;
    logic [5:0] calc, model;
    logic ok, err;
    logic [23:0] data;
    data = 24'($urandom());
    model = ref_crc(3'b101, data);
    send_frame(3'b101, data, model, 0, 1'b0, ab, me, dn, lat, calc, ok, err, ed);
    // Next frame starts right after the done cycle.
    send_frame(3'b010, 24'h00ABCD, ref_crc(3'b010, 24'h00ABCD), 0, 1'b0, ab, me, dn, lat, calc, ok, err, ed);
    tests_run++;
    if (!dn || ab !== 1'b0 || lat != 2 || calc !== ref_crc(3'b010, 24'h00ABCD) || ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_second done=%0b abort=%b lat=%0d calc=%02h ok=%b exp abort=0 lat=2 calc=%02h ok=1",
               dn, ab, lat, calc, ok, ref_crc(3'b010, 24'h00ABCD));
    end
    repeat (3) step();
    tests_run++;
    if (bus.crc_ok !== 1'b1 || bus.crc_done !== 1'b0 || bus.crc_err !== 1'b0 ||
        bus.crc_calc !== ref_crc(3'b010, 24'h00ABCD)) begin
      tests_failed++;
      $display("FAIL hold_after_done ok=%b done=%b err=%b calc=%02h exp ok=1 done=0 err=0 calc=%02h",
               bus.crc_ok, bus.crc_done, bus.crc_err, bus.crc_calc, ref_crc(3'b010, 24'h00ABCD));
    end
    bus.crc_mode = 3'b100;
    bus.frame_start = 1'b1;
    bus.nibble_valid = 1'b1;
    bus.nibble_in = 4'hF;
    step();
    tests_run++;
    if (bus.crc_ok !== 1'b0 || bus.busy !== 1'b1 || bus.abort !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_clears_ok ok=%b busy=%b abort=%b exp 0 1 0", bus.crc_ok, bus.busy, bus.abort);
    end
    bus.nibble_valid = 1'b0;
    bus.crc_mode = 3'b111;
    step();
    bus.frame_start = 1'b0;
    tests_run++;
    if (bus.abort !== 1'b1 || bus.mode_err !== 1'b1 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_invalid abort=%b mode_err=%b busy=%b exp 1 1 0", bus.abort, bus.mode_err, bus.busy);
    end
    step();
    $display("[TB] back-to-back and restart sequence done");
  endtask

  task automatic test_reset_mid_frame;
    bit ab, me, dn, ed, stray;
    int lat;
    logic [5:0] calc;
    logic ok, err;
    logic [15:0] outs;
    send_frame(3'b011, 24'h000, 6'h09, 0, 1'b0, ab, me, dn, lat, calc, ok, err, ed);
    bus.crc_mode = 3'b001;
    bus.frame_start = 1'b1;
    step();
    bus.frame_start = 1'b0;
    bus.nibble_valid = 1'b1;
    bus.rx_crc_valid = 1'b1;
    bus.rx_crc = 6'h05;
    bus.nibble_in = 4'h0;
    step();
    step();
    reset_n = 1'b0;
    step();
    outs = {bus.busy, bus.crc_calc, bus.crc_done, bus.crc_ok, bus.crc_err,
            bus.mode_err, bus.abort, 3'b000};
    tests_run++;
    if (outs !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs got=%04h exp=0000", outs);
    end
    reset_n = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.crc_done || bus.busy) stray = 1'b1;
    end
    bus.nibble_valid = 1'b0;
    bus.rx_crc_valid = 1'b0;
    tests_run++;
    if (stray) begin
      tests_failed++;
      $display("FAIL reset_mid_ignored saw crc_done or busy after reset exp none");
    end
    $display("[TB] reset mid-frame checked");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    test_reset();
    test_plan_vectors();
    test_random_frames();
    test_abort();
    test_mode_err();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
